addepreamble_ipg: RTL and testbench
===================================

// Module: addepreamble_ipg
//
// PURPOSE
//  Parametrised Ethernet TX framer: prefixes each outgoing frame with a
//  programmable preamble and SFD, then enforces a minimum inter-packet gap
//  before accepting the next frame. Unlike a fixed delay line, it
//  back-pressures the source (o_ready), so payload bytes are never lost.
//  Sits between the TX packet FIFO/CRC stage and the MII/RGMII byte path.
//
// PARAMETERS
//  PREAMBLE_LEN  7      preamble bytes before SFD (0 = SFD only)
//  PRE_BYTE      8'h55  preamble byte value
//  SFD_BYTE      8'hd5  start-of-frame delimiter value
//  IPG_CYCLES    12     idle byte-times enforced after each frame (>=1)
//
// PORTS
//  i_clk      in   1  clock
//  i_reset_n  in   1  asynchronous, active-low reset
//  i_ce       in   1  byte-time strobe; all state updates gated by it
//  i_en       in   1  1 = insert preamble+SFD; sampled only when leaving IDLE
//  i_v        in   1  source byte valid
//  i_d        in   8  source byte
//  i_last     in   1  marks final byte of frame (qualified by i_v)
//  o_ready    out  1  source byte accepted when i_v&&o_ready&&i_ce
//  o_v        out  1  output byte valid
//  o_d        out  8  output byte
//  o_last     out  1  output byte is last of frame
//  o_err      out  1  one-byte-time pulse: underrun (i_v low mid-frame)
//  o_busy     out  1  state != IDLE
//
// BEHAVIOUR
//  - Reset (async, i_reset_n=0): state IDLE, counter 0; o_v, o_d, o_last,
//    o_err all 0. Reset mid-frame aborts immediately; no o_err.
//  - Registered outputs change only on edges with i_ce=1; held otherwise.
//  - o_ready = (state==DATA), combinational from state only.
//  - Counter width = $clog2(max(PREAMBLE_LEN,IPG_CYCLES)+1).
//  - IDLE: o_v=0. On ce with i_v=1: latch en=i_en.
//      en=1, PREAMBLE_LEN>0: o_v<=1, o_d<=PRE_BYTE, cnt<=1 -> PRE.
//      en=1, PREAMBLE_LEN=0: o_v<=1, o_d<=SFD_BYTE -> DATA.
//      en=0: o_v stays 0 -> DATA.
//  - PRE: per ce: if cnt<PREAMBLE_LEN: o_d<=PRE_BYTE, cnt++;
//    else o_d<=SFD_BYTE -> DATA. Exactly PREAMBLE_LEN PRE bytes, then 1 SFD.
//  - DATA: per ce: i_v=1: o_v<=1, o_d<=i_d, o_last<=i_last;
//    if i_last -> GAP, cnt<=0. i_v=0 (underrun): o_v<=0, o_last<=0,
//    o_err<=1 for that byte-time -> GAP, cnt<=0.
//  - GAP: o_v<=0, o_last<=0, o_err<=0; cnt++ per ce; on ce with
//    cnt==IPG_CYCLES-1 -> IDLE. Gap = exactly IPG_CYCLES byte-times with
//    o_v=0 before the next preamble byte can appear (IDLE adds none
//    when i_v is already high; next PRE byte emitted on the following ce).
//  - Source may assert i_v in PRE/GAP/IDLE; it must hold i_v/i_d/i_last
//    until accepted. i_en changes outside IDLE are ignored.
//  - Frame output is gapless: SFD immediately followed by byte 0, data
//    bytes contiguous provided the source keeps i_v high.
//  - Latency (en=1): first data byte appears PREAMBLE_LEN+1 byte-times
//    after the first preamble byte; first preamble byte on the first ce
//    edge seeing i_v in IDLE. (en=0): first data byte one ce after that.
//
// TESTING
//  1 Defaults, en=1, frame 01,02,03,04 (last on 04) -> o_d 55 x7, d5,
//    01..04 contiguous, o_last only with 04, then 12 byte-times o_v=0.
//  2 en=0, same frame -> o_d 01..04 only; no 55/d5; first byte 2 ce
//    after i_v seen; o_last with 04.
//  3 i_ce alternating 1/0, en=1 -> identical byte sequence as test 1;
//    outputs held stable on every i_ce=0 cycle.
//  4 Underrun: i_v drops after 01,02 without i_last -> o_err=1 for one
//    byte-time, o_v=0, 12-byte GAP, then IDLE; o_busy falls.
//  5 Back-to-back: second frame i_v high right after first i_last ->
//    o_ready=0 for 12 gap + preamble + SFD; second frame starts with 55s.
//  6 i_reset_n=0 during 3rd preamble byte -> o_v=0, o_d=0 at once;
//    after release, new frame gets full 7x55 + d5.
//    Also sweep PREAMBLE_LEN=0 (d5 then data) and IPG_CYCLES=1.

Source files
------------

// File: rtl/addepreamble_ipg.sv
// Ethernet TX framer: prepends a programmable preamble + SFD to each frame and
// enforces a minimum inter-packet gap, back-pressuring the source via o_ready.
module addepreamble_ipg #(
  parameter int         PREAMBLE_LEN = 7,
  parameter logic [7:0] PRE_BYTE     = 8'h55,
  parameter logic [7:0] SFD_BYTE     = 8'hd5,
  parameter int         IPG_CYCLES   = 12
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_v,
  output logic [7:0] o_d,
  output logic       o_last,
  output logic       o_err,
  output logic       o_busy
);

  localparam int CNT_MAX = (PREAMBLE_LEN > IPG_CYCLES) ? PREAMBLE_LEN : IPG_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN);
  localparam logic [CW-1:0] GAP_LAST = CW'(IPG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          v_q,     v_d;
  logic [7:0]    d_q,     d_d;
  logic          last_q,  last_d;
  logic          err_q,   err_d;

  // State register: every stored bit only advances on a byte-time strobe.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      v_q     <= 1'b0;
      d_q     <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      d_q     <= d_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state: cnt tracks preamble bytes already sent in PRE, gap byte-times in GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_ce) begin
      unique case (state_q)
        IDLE: begin
          if (i_v) begin
            if (i_en && (PREAMBLE_LEN > 0)) begin
              state_d = PRE;
              cnt_d   = CNT_ONE;
            end else begin
              state_d = DATA;
            end
          end
        end
        PRE: begin
          if (cnt_q != PRE_LAST) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (!i_v || i_last) begin
            state_d = GAP;
            cnt_d   = '0;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output next-values; registered so the byte path is glitch-free and held on !i_ce.
  always_comb begin
    v_d    = v_q;
    d_d    = d_q;
    last_d = last_q;
    err_d  = err_q;
    if (i_ce) begin
      unique case (state_q)
        IDLE: begin
          v_d    = 1'b0;
          last_d = 1'b0;
          err_d  = 1'b0;
          if (i_v && i_en) begin
            v_d = 1'b1;
            d_d = (PREAMBLE_LEN > 0) ? PRE_BYTE : SFD_BYTE;
          end
        end
        PRE: begin
          v_d = 1'b1;
          d_d = (cnt_q != PRE_LAST) ? PRE_BYTE : SFD_BYTE;
        end
        DATA: begin
          if (i_v) begin
            v_d    = 1'b1;
            d_d    = i_d;
            last_d = i_last;
            err_d  = 1'b0;
          end else begin
            v_d    = 1'b0;
            last_d = 1'b0;
            err_d  = 1'b1;
          end
        end
        GAP: begin
          v_d    = 1'b0;
          last_d = 1'b0;
          err_d  = 1'b0;
        end
        default: begin
          v_d    = 1'b0;
          last_d = 1'b0;
          err_d  = 1'b0;
        end
      endcase
    end
  end

  assign o_ready = (state_q == DATA);
  assign o_busy  = (state_q != IDLE);
  assign o_v     = v_q;
  assign o_d     = d_q;
  assign o_last  = last_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_addepreamble_ipg.sv
// Scoreboard bench for addepreamble_ipg across three parameter sets
// (defaults, PREAMBLE_LEN=0, IPG_CYCLES=1), each with its own stimulus and monitor.
module tb_addepreamble_ipg;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       err;
    int         gap;   // required idle byte-times before this event, -1 = any
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_pl(int i);
    return (i == 1) ? 0 : 7;
  endfunction

  function automatic int cfg_ipg(int i);
    return (i == 2) ? 1 : 12;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int PL  = cfg_pl(g);
    localparam int IPG = cfg_ipg(g);

    logic       rst_n = 1'b0;
    logic       ce    = 1'b1;
    logic       en    = 1'b1;
    logic       iv    = 1'b0;
    logic [7:0] id    = '0;
    logic       ilast = 1'b0;
    logic       ordy, ov, olast, oerr, obusy;
    logic [7:0] od;
    logic       ce_q  = 1'b0;
    logic       rst_q = 1'b0;
    int         ce_mode = 0;
    bit         mon_off = 1'b0;
    bit         done    = 1'b0;
    int         gmin    = 0;
    int         pend_w  = 0;
    exp_t       exp_q[$];

    addepreamble_ipg #(
      .PREAMBLE_LEN(PL),
      .PRE_BYTE    (8'h55),
      .SFD_BYTE    (8'hd5),
      .IPG_CYCLES  (IPG)
    ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .i_ce     (ce),
      .i_en     (en),
      .i_v      (iv),
      .i_d      (id),
      .i_last   (ilast),
      .o_ready  (ordy),
      .o_v      (ov),
      .o_d      (od),
      .o_last   (olast),
      .o_err    (oerr),
      .o_busy   (obusy)
    );

    always @(negedge clk) begin
      case (ce_mode)
        0:       ce = 1'b1;
        1:       ce = ~ce;
        default: ce = ($urandom_range(0, 2) != 0);
      endcase
    end

    always @(posedge clk) begin
      ce_q  <= ce;
      rst_q <= rst_n;
    end

    // Monitor: pops one expected event per output event, checks holds on !ce edges.
    int         zeros = 0;
    logic       hv = 1'b0, hl = 1'b0, he = 1'b0;
    logic [7:0] hd = '0;
    exp_t       e;
    always @(negedge clk) begin
      if (!rst_n || !rst_q || mon_off) begin
        zeros = 0; hv = 1'b0; hl = 1'b0; he = 1'b0;
      end else if (ce_q) begin
        if (ov || oerr) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cfg%0d unexpected_output actual v=%b d=%h last=%b err=%b required no output",
                     g, ov, od, olast, oerr);
            hv = 1'b0; hl = 1'b0; he = 1'b0;
          end else begin
            e = exp_q.pop_front();
            if (ov !== !e.err || olast !== e.last || oerr !== e.err ||
                (!e.err && od !== e.d) || (e.gap >= 0 && zeros != e.gap)) begin
              errors++;
              $display("FAIL cfg%0d output_event actual v=%b d=%h last=%b err=%b gap=%0d required v=%b d=%h last=%b err=%b gap=%0d",
                       g, ov, od, olast, oerr, zeros, !e.err, e.d, e.last, e.err, e.gap);
            end
            hv = !e.err; hd = e.d; hl = e.last; he = e.err;
          end
          zeros = 0;
        end else begin
          zeros++;
          hv = 1'b0; hl = 1'b0; he = 1'b0;
        end
      end else begin
        checks++;
        if (ov !== hv || olast !== hl || oerr !== he || (hv && od !== hd)) begin
          errors++;
          $display("FAIL cfg%0d hold_on_no_ce actual v=%b d=%h last=%b err=%b required v=%b d=%h last=%b err=%b",
                   g, ov, od, olast, oerr, hv, hd, hl, he);
        end
      end
    end

    task automatic tick(output bit cedge, output bit acc);
      #4;
      cedge = ce;
      acc   = iv && ordy && ce;
      @(posedge clk);
      @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL cfg%0d %s actual=%h required=%h", g, nm, act, req);
      end
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic er, input int gp);
      exp_t x;
      x.d = d; x.last = l; x.err = er; x.gap = gp;
      exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
      bit c, a;
      iv = 1'b0;
      for (int k = 0; k < n;) begin
        tick(c, a);
        if (c) k++;
      end
      pend_w += n;
    endtask

    // One frame: w idle byte-times first; drop_at>0 drops i_v after drop_at accepted bytes.
    task automatic frame(input bit fen, input int len, input int drop_at, input int w, input bit seq);
      bit         c, a;
      int         gap, tmo;
      logic [7:0] b;
      idle(w);
      gap    = ((pend_w > gmin) ? pend_w : gmin) + (fen ? 0 : 1);
      pend_w = 0;
      if (fen) begin
        for (int p = 0; p < PL; p++) push(8'h55, 1'b0, 1'b0, (p == 0) ? gap : 0);
        push(8'hd5, 1'b0, 1'b0, (PL == 0) ? gap : 0);
      end
      en = fen;
      for (int i = 0; i < len; i++) begin
        if (drop_at != 0 && i == drop_at) begin
          iv = 1'b0;
          push(8'h00, 1'b0, 1'b1, 0);
          c = 1'b0;
          while (!c) tick(c, a);
          gmin = IPG;
          return;
        end
        b     = seq ? 8'(i + 1) : 8'($urandom);
        id    = b;
        ilast = (i == len - 1);
        iv    = 1'b1;
        push(b, ilast, 1'b0, (i == 0) ? (fen ? 0 : gap) : 0);
        a   = 1'b0;
        tmo = 0;
        while (!a && tmo < 2000) begin
          tick(c, a);
          tmo++;
        end
        if (!a) begin
          errors++;
          $display("FAIL cfg%0d accept_timeout actual=no accept required=accept byte %0d", g, i);
          iv = 1'b0;
          return;
        end
        if (i == 0) en = 1'($urandom);
      end
      iv    = 1'b0;
      ilast = 1'b0;
      gmin  = IPG;
    endtask

    initial begin
      bit c, a;
      int n, len, drop;
      repeat (3) @(negedge clk);
      chk("reset_o_v",     {7'd0, ov},    8'h00);
      chk("reset_o_d",     od,            8'h00);
      chk("reset_o_last",  {7'd0, olast}, 8'h00);
      chk("reset_o_err",   {7'd0, oerr},  8'h00);
      chk("reset_o_busy",  {7'd0, obusy}, 8'h00);
      chk("reset_o_ready", {7'd0, ordy},  8'h00);
      rst_n = 1'b1;

      frame(1'b1, 4, 0, 0, 1'b1);
      frame(1'b0, 4, 0, 5, 1'b1);
      ce_mode = 1;
      frame(1'b1, 4, 0, 3, 1'b1);
      ce_mode = 0;
      frame(1'b1, 5, 2, 1, 1'b1);
      idle(IPG - 1);
      chk("busy_in_gap_end", {7'd0, obusy}, 8'h01);
      idle(1);
      chk("busy_after_gap",  {7'd0, obusy}, 8'h00);
      chk("ready_after_gap", {7'd0, ordy},  8'h00);
      frame(1'b1, 4, 0, 2, 1'b0);
      frame(1'b1, 3, 0, 0, 1'b0);

      // Async reset in the middle of a preamble; outputs must clear without a clock.
      idle(IPG + 1);
      mon_off = 1'b1;
      en = 1'b1; id = 8'haa; ilast = 1'b0; iv = 1'b1;
      n = 0;
      while (n < 3) begin
        tick(c, a);
        if (c) n++;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_o_v",    {7'd0, ov},    8'h00);
      chk("midreset_o_d",    od,            8'h00);
      chk("midreset_o_err",  {7'd0, oerr},  8'h00);
      chk("midreset_o_busy", {7'd0, obusy}, 8'h00);
      iv = 1'b0;
      exp_q.delete();
      gmin = 0; pend_w = 0;
      @(negedge clk);
      rst_n = 1'b1;
      mon_off = 1'b0;
      frame(1'b1, 3, 0, 0, 1'b1);

      repeat (25) begin
        ce_mode = $urandom_range(0, 2);
        len  = $urandom_range(1, 6);
        drop = (len > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : 0;
        frame(1'($urandom), len, drop, $urandom_range(0, 3), 1'b0);
      end
      ce_mode = 0;
      idle(IPG + 2);
      chk("busy_at_end", {7'd0, obusy}, 8'h00);
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL cfg%0d scoreboard_drain actual=%0d pending required=0", g, exp_q.size());
      end
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(u[0].done && u[1].done && u[2].done) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (!(u[0].done && u[1].done && u[2].done)) begin
      errors++;
      $display("FAIL run_timeout actual=%b%b%b done required=111", u[2].done, u[1].done, u[0].done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
